// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

  // Clocks per oversample tick, integer floor.
  function automatic int calc_div(input int clk_freq, input int baud, input int ovs);
    return clk_freq / (baud * ovs);
  endfunction

endpackage

// File: rtl/uart_byte_receiver_if.sv
// Receiver output bundle towards data_encoder_decoder / mem_communication_interface.
interface uart_byte_receiver_if #(
  parameter int UART_WIDTH = 8
);
  import uart_pkg::*;

  // rx_new_byte_indicate pulses once when a frame's start bit is accepted; rxByteReady high
  // means no frame in progress and byteFromRx is valid and stable. There is no back-pressure.
  logic [UART_WIDTH-1:0] byteFromRx;
  logic                  rxByteReady;
  logic                  rx_new_byte_indicate;
  logic                  rx_frame_err;
  rx_state_t             dbg_state;

  modport master (
    output byteFromRx, rxByteReady, rx_new_byte_indicate, rx_frame_err, dbg_state
  );

  modport slave (
    input byteFromRx, rxByteReady, rx_new_byte_indicate, rx_frame_err, dbg_state
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick: one-cycle pulse every DIV clocks.
module uart_baud_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rstN,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN)              r_cnt <= '0;
    else if (r_cnt == LAST) r_cnt <= '0;
    else                    r_cnt <= r_cnt + CW'(1);
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_byte_receiver.sv
// Oversampling 8N1 UART receiver with start-glitch rejection and sticky framing error.
module uart_byte_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int UART_WIDTH = 8,
  parameter int DIV        = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE)
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                rx,
  uart_byte_receiver_if.master rx_if
);

  localparam int            SW     = $clog2(OVERSAMPLE);
  localparam int            BW     = $clog2(UART_WIDTH + 1);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(UART_WIDTH - 1);

  logic                  r_sync1, r_sync2;
  logic                  w_rx_s;
  logic                  w_tick;
  rx_state_t             r_state,   w_state_nxt;
  logic [SW-1:0]         r_s_cnt,   w_s_cnt_nxt;
  logic [BW-1:0]         r_bit_cnt, w_bit_cnt_nxt;
  logic [UART_WIDTH-1:0] r_shift,   w_shift_nxt;
  logic [UART_WIDTH-1:0] r_byte,    w_byte_nxt;
  logic                  r_ready,   w_ready_nxt;
  logic                  r_pulse,   w_pulse_nxt;
  logic                  r_err,     w_err_nxt;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rstN (rstN),
    .tick (w_tick)
  );

  // Two-flop synchronizer; idle-high reset so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rx_s = r_sync2;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state   <= IDLE;
      r_s_cnt   <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_byte    <= '0;
      r_ready   <= 1'b1;
      r_pulse   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_s_cnt   <= w_s_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_byte    <= w_byte_nxt;
      r_ready   <= w_ready_nxt;
      r_pulse   <= w_pulse_nxt;
      r_err     <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_s_cnt_nxt   = r_s_cnt;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_byte_nxt    = r_byte;
    w_ready_nxt   = r_ready;
    w_pulse_nxt   = 1'b0;
    w_err_nxt     = r_err;

    // Explicit wrap keeps the bit period correct for non-power-of-two OVERSAMPLE.
    if (w_tick && r_state != IDLE && r_state != BREAK)
      w_s_cnt_nxt = (r_s_cnt == S_LAST) ? '0 : r_s_cnt + SW'(1);

    case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt = START;
          w_s_cnt_nxt = '0;
        end
      end
      START: begin
        if (w_tick && r_s_cnt == S_MID) begin
          if (!w_rx_s) begin
            w_state_nxt   = DATA;
            w_s_cnt_nxt   = '0;
            w_bit_cnt_nxt = '0;
            w_pulse_nxt   = 1'b1;
            w_ready_nxt   = 1'b0;
            w_err_nxt     = 1'b0;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (w_tick && r_s_cnt == S_LAST) begin
          w_shift_nxt   = {w_rx_s, r_shift[UART_WIDTH-1:1]};
          w_bit_cnt_nxt = r_bit_cnt + BW'(1);
          if (r_bit_cnt == B_LAST) w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (w_tick && r_s_cnt == S_LAST) begin
          w_ready_nxt = 1'b1;
          if (w_rx_s) begin
            w_byte_nxt  = r_shift;
            w_state_nxt = IDLE;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        if (w_rx_s) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign rx_if.byteFromRx           = r_byte;
  assign rx_if.rxByteReady          = r_ready;
  assign rx_if.rx_new_byte_indicate = r_pulse;
  assign rx_if.rx_frame_err         = r_err;
  assign rx_if.dbg_state            = r_state;

endmodule

// File: tb/tb_uart_byte_receiver.sv
// Directed bench for uart_byte_receiver: a nominal-rate instance and a fast instance.
module tb_uart_byte_receiver;
  import uart_pkg::*;

  localparam int DIV_M = 27;
  localparam int OVS_M = 16;
  localparam int BIT_M = DIV_M * OVS_M;
  localparam int DIV_F = 2;
  localparam int OVS_F = 4;
  localparam int BIT_F = DIV_F * OVS_F;
  localparam int LOW_M = 9 * BIT_M;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic rstN = 1'b0;
  logic rx_m = 1'b1;
  logic rx_f = 1'b1;

  always #5 clk = ~clk;

  uart_byte_receiver_if #(.UART_WIDTH(8)) if_m ();
  uart_byte_receiver_if #(.UART_WIDTH(8)) if_f ();

  uart_byte_receiver #(
    .CLK_FREQ(50_000_000), .BAUD_RATE(115200), .OVERSAMPLE(OVS_M), .UART_WIDTH(8), .DIV(DIV_M)
  ) dut_m (
    .clk(clk), .rstN(rstN), .rx(rx_m), .rx_if(if_m.master)
  );

  uart_byte_receiver #(
    .CLK_FREQ(50_000_000), .BAUD_RATE(115200), .OVERSAMPLE(OVS_F), .UART_WIDTH(8), .DIV(DIV_F)
  ) dut_f (
    .clk(clk), .rstN(rstN), .rx(rx_f), .rx_if(if_f.master)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitors ----------------
  logic [7:0] exp_q[$];
  logic [7:0] exp_q_f[$];
  int   pulses_m = 0, rises_m = 0, low_run_m = 0, last_low_m = 0;
  int   pulses_f = 0, rises_f = 0;
  logic err_at_pulse_m = 1'b1;
  logic prev_ready_m = 1'b1;
  logic prev_ready_f = 1'b1;

  always @(negedge clk) begin
    if (if_m.rx_new_byte_indicate) begin
      pulses_m++;
      err_at_pulse_m = if_m.rx_frame_err;
    end
    if (!if_m.rxByteReady) begin
      low_run_m++;
    end else if (!prev_ready_m && rstN) begin
      rises_m++;
      last_low_m = low_run_m;
      low_run_m  = 0;
      if (!if_m.rx_frame_err) begin
        if (exp_q.size() == 0) check("sb_unexpected_m", {24'h0, if_m.byteFromRx}, 32'hFFFF_FFFF);
        else                   check("sb_byte_m", {24'h0, if_m.byteFromRx}, {24'h0, exp_q.pop_front()});
      end
    end else if (!prev_ready_m) begin
      low_run_m = 0;
    end
    prev_ready_m = if_m.rxByteReady;
  end

  always @(negedge clk) begin
    if (if_f.rx_new_byte_indicate) pulses_f++;
    if (if_f.rxByteReady && !prev_ready_f && rstN) begin
      rises_f++;
      if (!if_f.rx_frame_err) begin
        if (exp_q_f.size() == 0) check("sb_unexpected_f", {24'h0, if_f.byteFromRx}, 32'hFFFF_FFFF);
        else                     check("sb_byte_f", {24'h0, if_f.byteFromRx}, {24'h0, exp_q_f.pop_front()});
      end
    end
    prev_ready_f = if_f.rxByteReady;
  end

  // ---------------- drivers ----------------
  task automatic drive_line(input bit fast, input logic v, input int n);
    if (fast) rx_f = v;
    else      rx_m = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit fast, input logic [7:0] d, input logic stop);
    int bl;
    bl = fast ? BIT_F : BIT_M;
    drive_line(fast, 1'b0, bl);
    for (int i = 0; i < 8; i++) drive_line(fast, d[i], bl);
    drive_line(fast, stop, bl);
  endtask

  task automatic wait_idle(input bit fast, input string tag);
    int   n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 4 * BIT_M) begin
      if (fast) ok = if_f.rxByteReady && (if_f.dbg_state == IDLE);
      else      ok = if_m.rxByteReady && (if_m.dbg_state == IDLE);
      if (!ok) begin
        @(negedge clk);
        n++;
      end
    end
    check(tag, {31'h0, ok}, 32'h1);
  endtask

  // ---------------- stimulus ----------------
  int p0, r0;

  initial begin
    repeat (5) @(negedge clk);
    check("rst_byte",  {24'h0, if_m.byteFromRx}, 32'h0);
    check("rst_ready", {31'h0, if_m.rxByteReady}, 32'h1);
    check("rst_pulse", {31'h0, if_m.rx_new_byte_indicate}, 32'h0);
    check("rst_err",   {31'h0, if_m.rx_frame_err}, 32'h0);
    check("rst_state", 32'(if_m.dbg_state), 32'(IDLE));
    check("rst_ready_f", {31'h0, if_f.rxByteReady}, 32'h1);
    rstN = 1'b1;
    repeat (10) @(negedge clk);

    // Nominal frame 0xA5
    p0 = pulses_m;
    exp_q.push_back(8'hA5);
    send_frame(1'b0, 8'hA5, 1'b1);
    wait_idle(1'b0, "a5_idle");
    check("a5_pulses",  32'(pulses_m - p0), 32'd1);
    check("a5_err",     {31'h0, if_m.rx_frame_err}, 32'h0);
    check("a5_byte",    {24'h0, if_m.byteFromRx}, 32'hA5);
    check("a5_low_len", 32'(last_low_m), 32'(LOW_M));

    // Short low glitch rejected
    p0 = pulses_m;
    r0 = rises_m;
    drive_line(1'b0, 1'b0, 100);
    drive_line(1'b0, 1'b1, 400);
    check("gl_pulses", 32'(pulses_m - p0), 32'd0);
    check("gl_rises",  32'(rises_m - r0), 32'd0);
    check("gl_ready",  {31'h0, if_m.rxByteReady}, 32'h1);
    check("gl_byte",   {24'h0, if_m.byteFromRx}, 32'hA5);
    check("gl_state",  32'(if_m.dbg_state), 32'(IDLE));

    // Framing error with line held low, then recovery on 0x81
    p0 = pulses_m;
    send_frame(1'b0, 8'h3C, 1'b0);
    drive_line(1'b0, 1'b0, 3 * BIT_M);
    check("fe_err",    {31'h0, if_m.rx_frame_err}, 32'h1);
    check("fe_byte",   {24'h0, if_m.byteFromRx}, 32'hA5);
    check("fe_ready",  {31'h0, if_m.rxByteReady}, 32'h1);
    check("fe_pulses", 32'(pulses_m - p0), 32'd1);
    check("fe_state",  32'(if_m.dbg_state), 32'(BREAK));
    drive_line(1'b0, 1'b1, BIT_M);
    check("fe_release_state", 32'(if_m.dbg_state), 32'(IDLE));
    check("fe_sticky_err",    {31'h0, if_m.rx_frame_err}, 32'h1);
    p0 = pulses_m;
    exp_q.push_back(8'h81);
    send_frame(1'b0, 8'h81, 1'b1);
    wait_idle(1'b0, "r81_idle");
    check("r81_pulses",       32'(pulses_m - p0), 32'd1);
    check("r81_err_at_pulse", {31'h0, err_at_pulse_m}, 32'h0);
    check("r81_err",          {31'h0, if_m.rx_frame_err}, 32'h0);
    check("r81_byte",         {24'h0, if_m.byteFromRx}, 32'h81);

    // Back-to-back frames, no idle gap
    p0 = pulses_m;
    r0 = rises_m;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    send_frame(1'b0, 8'h00, 1'b1);
    send_frame(1'b0, 8'hFF, 1'b1);
    send_frame(1'b0, 8'h55, 1'b1);
    wait_idle(1'b0, "b2b_idle");
    check("b2b_pulses", 32'(pulses_m - p0), 32'd3);
    check("b2b_rises",  32'(rises_m - r0), 32'd3);
    check("b2b_byte",   {24'h0, if_m.byteFromRx}, 32'h55);
    check("b2b_drain",  32'(exp_q.size()), 32'd0);

    // Reset in the middle of data bit 4 of 0xF0
    drive_line(1'b0, 1'b0, BIT_M);
    for (int i = 0; i < 4; i++) drive_line(1'b0, 1'b0, BIT_M);
    drive_line(1'b0, 1'b1, BIT_M / 2);
    check("mr_state_before", 32'(if_m.dbg_state), 32'(DATA));
    rstN = 1'b0;
    #1;
    check("mr_byte",  {24'h0, if_m.byteFromRx}, 32'h0);
    check("mr_ready", {31'h0, if_m.rxByteReady}, 32'h1);
    check("mr_pulse", {31'h0, if_m.rx_new_byte_indicate}, 32'h0);
    check("mr_err",   {31'h0, if_m.rx_frame_err}, 32'h0);
    check("mr_state", 32'(if_m.dbg_state), 32'(IDLE));
    @(negedge clk);
    drive_line(1'b0, 1'b1, 5);
    rstN = 1'b1;
    drive_line(1'b0, 1'b1, 2 * BIT_M);
    exp_q.push_back(8'h12);
    send_frame(1'b0, 8'h12, 1'b1);
    wait_idle(1'b0, "r12_idle");
    check("r12_byte", {24'h0, if_m.byteFromRx}, 32'h12);

    // Fast configuration: LSB-first ordering
    p0 = pulses_f;
    drive_line(1'b1, 1'b1, 20);
    exp_q_f.push_back(8'h01);
    send_frame(1'b1, 8'h01, 1'b1);
    wait_idle(1'b1, "f01_idle");
    check("f01_byte", {24'h0, if_f.byteFromRx}, 32'h01);
    exp_q_f.push_back(8'h80);
    send_frame(1'b1, 8'h80, 1'b1);
    wait_idle(1'b1, "f80_idle");
    check("f80_byte",   {24'h0, if_f.byteFromRx}, 32'h80);
    check("f_pulses",   32'(pulses_f - p0), 32'd2);
    check("f_err",      {31'h0, if_f.rx_frame_err}, 32'h0);

    drive_line(1'b0, 1'b1, 10);
    check("sb_drain_m", 32'(exp_q.size()), 32'd0);
    check("sb_drain_f", 32'(exp_q_f.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
